// File: rtl/wand_bus_tx_if.sv
// Handshake and line signals of one wired-AND transmitter node.
// The master side requests frames and supplies the resolved line value; the slave side is the node.
interface wand_bus_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              bus_in;
  logic              bus_oe;
  logic              busy;
  logic              done;
  logic              lost;
  logic              err;
  logic [DATA_W-1:0] rx_data;

  modport master (
    output start, tx_data, bus_in,
    input  bus_oe, busy, done, lost, err, rx_data
  );

  modport slave (
    input  start, tx_data, bus_in,
    output bus_oe, busy, done, lost, err, rx_data
  );
endinterface

// File: rtl/wand_bus_tx.sv
// Open-drain serial transmitter with read-back and bitwise arbitration.
// It sends a frame of SOF, DATA_W bits MSB first and then STOP, and it captures whatever frame wins the line.
module wand_bus_tx #(
  parameter int DATA_W       = 8,
  parameter int BIT_CYCLES   = 4,
  parameter int SAMPLE_POINT = 2
) (
  input  logic           clk,
  input  logic           rst,
  wand_bus_tx_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SOF, DATA, STOP} state_t;

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_SAMPLE = CW'(SAMPLE_POINT);
  localparam logic [IW-1:0] IDX_TOP    = IW'(DATA_W - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);

  state_t            state_q, state_n;
  logic [CW-1:0]     cyc_q, cyc_n;
  logic [IW-1:0]     idx_q, idx_n, idx_dec;
  logic [DATA_W-1:0] tx_q, tx_n;
  logic [DATA_W-1:0] rx_q, rx_n;
  logic              oe_q, oe_n;
  logic              lost_q, lost_n;
  logic              err_q, err_n;
  logic              done_q, done_n;
  logic              sync1, sync2;
  logic              sample, last, line, own_bit;

  // The line idles high, so the synchronizer resets to 1 to avoid a false low after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.bus_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      oe_q    <= 1'b0;
      lost_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cyc_q   <= cyc_n;
      idx_q   <= idx_n;
      tx_q    <= tx_n;
      rx_q    <= rx_n;
      oe_q    <= oe_n;
      lost_q  <= lost_n;
      err_q   <= err_n;
      done_q  <= done_n;
    end
  end

  // The drive for a bit is registered on the edge that opens that bit, so bus_oe only moves at cyc 0.
  always_comb begin
    state_n = state_q;
    cyc_n   = cyc_q;
    idx_n   = idx_q;
    tx_n    = tx_q;
    rx_n    = rx_q;
    oe_n    = oe_q;
    lost_n  = lost_q;
    err_n   = err_q;
    done_n  = 1'b0;
    sample  = (cyc_q == CYC_SAMPLE);
    last    = (cyc_q == CYC_LAST);
    line    = sync2;
    own_bit = tx_q[idx_q];
    idx_dec = idx_q - IDX_ONE;

    if (state_q != IDLE) begin
      cyc_n = last ? '0 : cyc_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        cyc_n = '0;
        if (bus.start) begin
          state_n = SOF;
          tx_n    = bus.tx_data;
          rx_n    = '0;
          lost_n  = 1'b0;
          err_n   = 1'b0;
          idx_n   = IDX_TOP;
          oe_n    = 1'b1;
        end
      end
      SOF: begin
        if (sample && line) begin
          err_n = 1'b1;
        end
        if (last) begin
          state_n = DATA;
          oe_n    = ~tx_q[IDX_TOP];
        end
      end
      DATA: begin
        if (sample) begin
          rx_n[idx_q] = line;
          if (!lost_q) begin
            if (own_bit && !line) begin
              lost_n = 1'b1;
            end
            if (!own_bit && line) begin
              err_n = 1'b1;
            end
          end
        end
        // A loss detected in the final sample of a bit must already silence the next bit.
        if (last) begin
          if (idx_q == '0) begin
            state_n = STOP;
            oe_n    = 1'b0;
          end else begin
            idx_n = idx_dec;
            oe_n  = ~tx_q[idx_dec] & ~lost_n;
          end
        end
      end
      STOP: begin
        if (sample && !line) begin
          err_n = 1'b1;
        end
        if (last) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        oe_n    = 1'b0;
      end
    endcase
  end

  assign bus.bus_oe  = oe_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.lost    = lost_q;
  assign bus.err     = err_q;
  assign bus.rx_data = rx_q;

endmodule

// File: tb/tb_wand_bus_tx.sv
// Directed bench for wand_bus_tx: solo frames, arbitration against a lockstep competitor, stuck lines,
// start while busy, and asynchronous reset in the middle of a frame.
module tb_wand_bus_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       force0 = 1'b0;
  logic       force1 = 1'b0;
  logic       comp_en = 1'b0;
  logic [7:0] comp_data = 8'h00;
  logic       comp_active = 1'b0;
  int         comp_cnt = 0;
  logic       comp_oe;
  int         errors = 0;
  int         checks = 0;

  int          busy_cnt, done_cnt, extra;
  logic [9:0]  oe_pat;
  logic [39:0] lost_hist, err_hist;

  wand_bus_tx_if #(.DATA_W(8)) bus ();

  wand_bus_tx #(.DATA_W(8), .BIT_CYCLES(4), .SAMPLE_POINT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Competitor node: starts on the same edge as the DUT and never backs off.
  always @(posedge clk) begin
    if (bus.start && comp_en && !comp_active) begin
      comp_active <= 1'b1;
      comp_cnt    <= 0;
    end else if (comp_active) begin
      if (comp_cnt == 39) comp_active <= 1'b0;
      comp_cnt <= comp_cnt + 1;
    end
  end

  always_comb begin
    int slot;
    slot    = comp_cnt / 4;
    comp_oe = 1'b0;
    if (comp_active && comp_en) begin
      if (slot == 0) comp_oe = 1'b1;
      else if (slot <= 8) comp_oe = ~comp_data[8 - slot];
    end
  end

  assign bus.bus_in = force1 | ~(bus.bus_oe | comp_oe | force0);

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] data);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.tx_data = data;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Entered at frame cycle 0; returns on the negedge where done is seen (or after the cycle budget).
  task automatic watch_frame(input int inject_k, output int b_cnt, output logic [9:0] pat,
                             output logic [39:0] l_hist, output logic [39:0] e_hist, output int d_cnt);
    b_cnt = 0; d_cnt = 0; pat = '0; l_hist = '0; e_hist = '0;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      bus.start = (k == inject_k);
      if (k == inject_k) bus.tx_data = 8'h3C;
      if (bus.busy) b_cnt++;
      if (k < 40) begin
        if (k % 4 == 1) pat[9 - k / 4] = bus.bus_oe;
        l_hist[k] = bus.lost;
        e_hist[k] = bus.err;
      end
      if (bus.done) begin
        d_cnt++;
        break;
      end
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.tx_data = 8'h00;
    #12;
    check_output("reset bus_oe", 32'(bus.bus_oe), 32'd0);
    check_output("reset busy", 32'(bus.busy), 32'd0);
    check_output("reset done", 32'(bus.done), 32'd0);
    check_output("reset lost", 32'(bus.lost), 32'd0);
    check_output("reset err", 32'(bus.err), 32'd0);
    check_output("reset rx_data", 32'(bus.rx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] solo frame 0xA5");
    apply_stimulus(8'hA5);
    watch_frame(-1, busy_cnt, oe_pat, lost_hist, err_hist, done_cnt);
    check_output("solo busy cycles", 32'(busy_cnt), 32'd40);
    check_output("solo oe pattern", 32'(oe_pat), 32'h2B4);
    check_output("solo done", 32'(done_cnt), 32'd1);
    check_output("solo rx_data", 32'(bus.rx_data), 32'hA5);
    check_output("solo lost", 32'(bus.lost), 32'd0);
    check_output("solo err", 32'(bus.err), 32'd0);
    @(negedge clk);
    check_output("solo done width", 32'(bus.done), 32'd0);
    check_output("solo rx hold", 32'(bus.rx_data), 32'hA5);
    repeat (2) @(negedge clk);

    $display("[TB] arbitration 0xA5 vs 0xA1");
    comp_en = 1'b1;
    comp_data = 8'hA1;
    apply_stimulus(8'hA5);
    watch_frame(-1, busy_cnt, oe_pat, lost_hist, err_hist, done_cnt);
    check_output("arb lost before bit2 sample", 32'(lost_hist[26]), 32'd0);
    check_output("arb lost after bit2 sample", 32'(lost_hist[27]), 32'd1);
    check_output("arb oe pattern", 32'(oe_pat), 32'h2B0);
    check_output("arb done", 32'(done_cnt), 32'd1);
    check_output("arb rx_data", 32'(bus.rx_data), 32'hA1);
    check_output("arb lost", 32'(bus.lost), 32'd1);
    check_output("arb err", 32'(bus.err), 32'd0);
    repeat (2) @(negedge clk);

    $display("[TB] equal contenders 0xA5");
    comp_data = 8'hA5;
    apply_stimulus(8'hA5);
    watch_frame(-1, busy_cnt, oe_pat, lost_hist, err_hist, done_cnt);
    check_output("equal done", 32'(done_cnt), 32'd1);
    check_output("equal rx_data", 32'(bus.rx_data), 32'hA5);
    check_output("equal lost", 32'(bus.lost), 32'd0);
    check_output("equal err", 32'(bus.err), 32'd0);
    comp_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] line stuck low");
    force0 = 1'b1;
    apply_stimulus(8'hA5);
    watch_frame(-1, busy_cnt, oe_pat, lost_hist, err_hist, done_cnt);
    check_output("stuck0 err before stop sample", 32'(err_hist[38]), 32'd0);
    check_output("stuck0 err after stop sample", 32'(err_hist[39]), 32'd1);
    check_output("stuck0 rx_data", 32'(bus.rx_data), 32'h00);
    check_output("stuck0 lost", 32'(bus.lost), 32'd1);
    check_output("stuck0 err", 32'(bus.err), 32'd1);
    force0 = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] line stuck high");
    force1 = 1'b1;
    apply_stimulus(8'hA5);
    watch_frame(-1, busy_cnt, oe_pat, lost_hist, err_hist, done_cnt);
    check_output("stuck1 err before sof sample", 32'(err_hist[2]), 32'd0);
    check_output("stuck1 err after sof sample", 32'(err_hist[3]), 32'd1);
    check_output("stuck1 rx_data", 32'(bus.rx_data), 32'hFF);
    check_output("stuck1 lost", 32'(bus.lost), 32'd0);
    check_output("stuck1 err", 32'(bus.err), 32'd1);
    force1 = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] start while busy");
    apply_stimulus(8'hA5);
    watch_frame(10, busy_cnt, oe_pat, lost_hist, err_hist, done_cnt);
    check_output("busy-start busy cycles", 32'(busy_cnt), 32'd40);
    check_output("busy-start oe pattern", 32'(oe_pat), 32'h2B4);
    check_output("busy-start rx_data", 32'(bus.rx_data), 32'hA5);
    extra = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.busy || bus.done) extra++;
    end
    check_output("busy-start no second frame", 32'(extra), 32'd0);

    $display("[TB] start on done cycle");
    apply_stimulus(8'hA5);
    watch_frame(-1, busy_cnt, oe_pat, lost_hist, err_hist, done_cnt);
    check_output("restart first done", 32'(done_cnt), 32'd1);
    bus.start   = 1'b1;
    bus.tx_data = 8'h3C;
    @(negedge clk);
    bus.start   = 1'b0;
    check_output("restart busy", 32'(bus.busy), 32'd1);
    check_output("restart sof drive", 32'(bus.bus_oe), 32'd1);
    watch_frame(-1, busy_cnt, oe_pat, lost_hist, err_hist, done_cnt);
    check_output("restart busy cycles", 32'(busy_cnt), 32'd40);
    check_output("restart rx_data", 32'(bus.rx_data), 32'h3C);
    repeat (2) @(negedge clk);

    $display("[TB] reset mid-frame");
    apply_stimulus(8'hA5);
    repeat (17) @(negedge clk);
    check_output("midreset drive in bit4", 32'(bus.bus_oe), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_output("midreset bus_oe", 32'(bus.bus_oe), 32'd0);
    check_output("midreset busy", 32'(bus.busy), 32'd0);
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check_output("midreset no done", 32'(extra), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    apply_stimulus(8'h5A);
    watch_frame(-1, busy_cnt, oe_pat, lost_hist, err_hist, done_cnt);
    check_output("post-reset busy cycles", 32'(busy_cnt), 32'd40);
    check_output("post-reset oe pattern", 32'(oe_pat), 32'h34A);
    check_output("post-reset done", 32'(done_cnt), 32'd1);
    check_output("post-reset rx_data", 32'(bus.rx_data), 32'h5A);
    check_output("post-reset lost", 32'(bus.lost), 32'd0);
    check_output("post-reset err", 32'(bus.err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wand_bus_tx.md
Name: wand_bus_tx

Overview:
- Serial transmitter node for a single-bit wired-AND (open-drain) shared line; the active driver that sits on a triand-resolved bus.
- Sends a start-of-frame bit, then DATA_W data bits MSB first, then a stop bit. The node only ever drives low or releases the line.
- Reads every bit back and performs bitwise arbitration: on loss it stops driving and keeps listening, capturing the winning frame.
- Several instances share one wired-AND net; the top level resolves it with a triand net.

Parameters:
- DATA_W, 8, frame payload width in bits (>=1).
- BIT_CYCLES, 4, clock cycles per bit period (>=3).
- SAMPLE_POINT, 2, cycle index within a bit at which the synchronized line is sampled; legal range 2..BIT_CYCLES-1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to transmit tx_data; honoured only when busy=0.
- tx_data  input  DATA_W  payload, captured when start is accepted.
- bus_in  input  1  resolved wired-AND line value (asynchronous to clk).
- bus_oe  output  1  1 = pull line low; 0 = release (top level maps this to 1'b0/1'bz).
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at end of frame.
- lost  output  1  arbitration lost in the last frame; held until next accepted start.
- err  output  1  bit error in the last frame; held until next accepted start.
- rx_data  output  DATA_W  data bits read back from the line in the last frame.

Behaviour:
- Reset (async): bus_oe=0, busy=0, done=0, lost=0, err=0, rx_data=0, FSM=IDLE, synchronizer flops=1. Reset mid-frame releases the line immediately, with no wait for a clock edge.
- bus_in passes through a 2-flop synchronizer (reset value 1). Sampling uses the synchronized value; a SAMPLE_POINT of 2 or more guarantees the node sees its own drive.
- FSM states: IDLE -> SOF -> DATA -> STOP -> IDLE.
- IDLE: start=1 at an edge captures tx_data and clears lost, err and rx_data. On the next cycle the FSM is in SOF, busy=1 and bit-cycle counter cyc=0.
- Each bit lasts BIT_CYCLES cycles, cyc 0..BIT_CYCLES-1. bus_oe changes only at cyc=0 of a bit, except on reset.
- SOF: bus_oe=1. Sample at SAMPLE_POINT; a read of 1 sets err (line stuck high). The frame still continues.
- DATA: bit index i runs DATA_W-1 down to 0. bus_oe = ~tx_bit AND ~lost. The sampled value is stored into rx_data[i].
  - Sample 0 while own bit is 1 and not yet lost: set lost. From the next bit onward bus_oe=0 for the rest of the frame; sampling continues.
  - Sample 1 while own bit is 0 and not lost: set err.
- STOP: bus_oe=0. A sample of 0 sets err.
- After the last cycle of STOP: return to IDLE with busy=0 and done=1 for exactly that one cycle. lost, err and rx_data are valid on that cycle and hold afterwards.
- Frame length is (DATA_W+2)*BIT_CYCLES cycles of busy=1. A new start on the done cycle is accepted.
- start while busy=1 is ignored, with no queueing.
- The tx_data capture register is internal; tx_data may change after acceptance.
- If lost and err conditions coincide, both are reported independently.

Test Plan:
- Solo frame: DATA_W=8, BIT_CYCLES=4, start with tx_data=0xA5, bench line = ~bus_oe.
  - Required: busy high for exactly 40 cycles.
  - Required: bus_oe pattern SOF=1, then data bits 0,1,0,1,1,0,1,0 (bus_oe = ~bit), stop=0.
  - Required: done pulses once; rx_data=0xA5, lost=0, err=0.
- Arbitration loss: competitor model drives 0xA1 in lockstep while DUT sends 0xA5.
  - Required: lost sets at data bit 2 and bus_oe=0 from bit 1 on.
  - Required: done with rx_data=0xA1, lost=1, err=0.
- Equal contenders: competitor also sends 0xA5.
  - Required: lost=0, err=0, rx_data=0xA5.
- Stuck line:
  - Line forced 0 throughout: err=1 (set at STOP), rx_data=0x00, lost=1.
  - Line forced 1 throughout: err=1 (set at SOF), rx_data=0xFF.
- Start while busy: pulse start with 0x3C at frame cycle 10 of a 0xA5 frame.
  - Required: frame unaffected, rx_data=0xA5, no second frame.
  - Required: start asserted on the done cycle begins a new frame immediately.
- Reset mid-frame: assert rst asynchronously during DATA bit 4.
  - Required: bus_oe=0 and busy=0 without a clock edge; done does not pulse.
  - Required: after deassert, a fresh 0x5A frame completes correctly.
